paddle_draw: RTL and testbench
==============================

# paddle_draw

Renders the breakout paddle into the 160x120 VGA framebuffer. On a start request it erases the paddle at its previously drawn position with the background colour, then draws it at the new position, emitting one pixel write per clock to the VGA adapter's plot interface. It sits between the paddle position register, which supplies the paddle centre X, and the VGA adapter. It is the framebuffer-side consumer of paddle position updates.

## Interface

Parameters:
- HALF_W, 8: paddle half-width in pixels; paddle spans centre-HALF_W .. centre+HALF_W (2*HALF_W+1 columns).
- H, 2: paddle height in rows.
- Y_ROW, 110: top row of paddle.
- SCREEN_W, 160: visible columns; pixels at x >= SCREEN_W or x < 0 are clipped.
- RESET_X, 70: centre X assumed drawn after reset.
- PADDLE_COL, 3'b111: draw colour.
- BG_COL, 3'b000: erase colour.

Ports:
- clk, in, 1: system clock, rising edge.
- reset, in, 1: asynchronous, active-high reset.
- x_in, in, 8: requested paddle centre X, sampled when start is accepted.
- start, in, 1: redraw request; accepted only in IDLE.
- busy, out, 1: high while erasing or drawing.
- done, out, 1: one-cycle pulse when the redraw completes.
- vga_x, out, 8: pixel column.
- vga_y, out, 7: pixel row.
- colour, out, 3: pixel colour.
- plot, out, 1: pixel write strobe; vga_x, vga_y and colour are valid when plot=1.

## Operation

- Registers:
  - old_x (8b): last drawn centre.
  - new_x (8b): latched request.
  - col counter: 0..2*HALF_W.
  - row counter: 0..H-1.
  - FSM state.
- FSM states: IDLE, ERASE, DRAW, DONE.
- IDLE: when start=1, latch new_x<=x_in and clear the counters.
  - If x_in != old_x, go to ERASE.
  - Otherwise skip straight to DRAW.
- ERASE: sweep the paddle box at old_x with colour=BG_COL.
  - Row-major order: row outer loop, column inner loop, ascending x.
  - After the last pixel (row=H-1, col=2*HALF_W), go to DRAW with counters cleared.
- DRAW: same sweep at new_x with colour=PADDLE_COL.
  - After the last pixel, set old_x<=new_x and go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Pixel address:
  - s = centre + col, computed 9-bit.
  - vga_x = (s - HALF_W)[7:0].
  - vga_y = Y_ROW + row.
- Clipping: plot=0 when s < HALF_W or s - HALF_W >= SCREEN_W. A clipped pixel still consumes its cycle, so phase length is fixed.
- start while busy or in DONE is ignored (not queued). x_in changes after acceptance have no effect.
- Reset (asynchronous, any state, including mid-sweep):
  - State returns to IDLE; counters clear.
  - old_x=RESET_X, new_x=RESET_X.
  - Outputs: plot=0, busy=0, done=0, vga_x=0, vga_y=0, colour=0.
  - Partially drawn pixels are not repaired.

## Timing

- All outputs are registered.
- With start accepted at edge 0, phase length is N=(2*HALF_W+1)*H (34 with defaults).
- Erase path (x_in != old_x):
  - Erase pixels are presented in cycles 1..N.
  - Draw pixels are presented in cycles N+1..2N.
  - done=1 in cycle 2N+1.
- Skip path (x_in == old_x):
  - Draw pixels are presented in cycles 1..N.
  - done=1 in cycle N+1.
- busy=1 from cycle 1 through the last pixel cycle; busy=0 in the done cycle.
- A new start is accepted no earlier than the cycle after done (back-to-back redraws have a one-cycle IDLE gap).
- Throughput: one pixel per clock. No backpressure; the VGA adapter accepts a write every cycle.

## Test plan

- Reset mid-DRAW (assert reset at cycle 10) -> plot, busy and done deassert immediately (asynchronous); next start with x_in=70 takes the skip path and takes N+1 cycles to done.
- After reset, start with x_in=70 -> no erase; 34 plots at x=62..78, y=110..111, colour 111; done in cycle 35.
- Then start with x_in=71:
  - Cycles 1..34: 34 erase plots at x=62..78, colour 000.
  - Cycles 35..68: draw plots at x=63..79, colour 111.
  - done in cycle 69; old_x=71.
- Left clip, x_in=3:
  - Erase phase is 34 cycles.
  - Draw phase plots only x=0..11 (12 columns x 2 rows = 24 plots); the 10 clipped slots have plot=0.
  - done timing unchanged.
- Right clip, x_in=155 -> draw plots only x=147..159; no plot with vga_x >= 160.
- Start pulsed at cycles 5 and 40 of a redraw -> ignored; exactly one done; old_x equals the first accepted x_in.

Source files
------------

// File: rtl/paddle_draw.sv
// Paddle renderer: erases the paddle at its last drawn centre, then draws it at
// the requested centre, one pixel write per clock towards the VGA adapter.
module paddle_draw #(
  parameter int unsigned HALF_W     = 8,
  parameter int unsigned H          = 2,
  parameter int unsigned Y_ROW      = 110,
  parameter int unsigned SCREEN_W   = 160,
  parameter int unsigned RESET_X    = 70,
  parameter logic [2:0]  PADDLE_COL = 3'b111,
  parameter logic [2:0]  BG_COL     = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] x_in,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot
);

  localparam int unsigned NCols = 2 * HALF_W + 1;
  localparam int unsigned ColW  = (NCols > 1) ? $clog2(NCols) : 1;
  localparam int unsigned RowW  = (H > 1) ? $clog2(H) : 1;

  localparam logic [ColW-1:0] ColLast = ColW'(NCols - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(H - 1);

  typedef enum logic [1:0] {StIdle, StErase, StDraw, StDone} state_e;

  state_e          state_q, state_d;
  logic [7:0]      old_x_q, old_x_d;
  logic [7:0]      new_x_q, new_x_d;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;

  logic       busy_d, done_d, plot_d;
  logic [7:0] vga_x_d;
  logic [6:0] vga_y_d;
  logic [2:0] colour_d;

  logic [7:0] centre;
  logic [8:0] s;
  logic [8:0] x_off;
  logic       in_view;
  logic       last_pix;

  // State, position and sweep counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      old_x_q <= 8'(RESET_X);
      new_x_q <= 8'(RESET_X);
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      old_x_q <= old_x_d;
      new_x_q <= new_x_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Next-state logic: accept requests in idle and walk the row-major sweep.
  always_comb begin
    state_d  = state_q;
    old_x_d  = old_x_q;
    new_x_d  = new_x_q;
    col_d    = col_q;
    row_d    = row_q;
    last_pix = (col_q == ColLast) && (row_q == RowLast);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          new_x_d = x_in;
          col_d   = '0;
          row_d   = '0;
          state_d = (x_in != old_x_q) ? StErase : StDraw;
        end
      end
      StErase, StDraw: begin
        if (last_pix) begin
          col_d = '0;
          row_d = '0;
          if (state_q == StErase) begin
            state_d = StDraw;
          end else begin
            old_x_d = new_x_q;
            state_d = StDone;
          end
        end else if (col_q == ColLast) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode from next-state values so the registered outputs line up with the state.
  always_comb begin
    centre   = (state_d == StErase) ? old_x_q : new_x_d;
    s        = {1'b0, centre} + 9'(col_d);
    x_off    = s - 9'(HALF_W);
    // Clipped pixels still occupy their cycle; only the strobe is suppressed.
    in_view  = (s >= 9'(HALF_W)) && (x_off < 9'(SCREEN_W));
    busy_d   = 1'b0;
    plot_d   = 1'b0;
    vga_x_d  = '0;
    vga_y_d  = '0;
    colour_d = '0;
    done_d   = (state_d == StDone);
    if (state_d == StErase || state_d == StDraw) begin
      busy_d   = 1'b1;
      plot_d   = in_view;
      vga_x_d  = x_off[7:0];
      vga_y_d  = 7'(Y_ROW) + 7'(row_d);
      colour_d = (state_d == StErase) ? BG_COL : PADDLE_COL;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      plot   <= 1'b0;
      vga_x  <= '0;
      vga_y  <= '0;
      colour <= '0;
    end else begin
      busy   <= busy_d;
      done   <= done_d;
      plot   <= plot_d;
      vga_x  <= vga_x_d;
      vga_y  <= vga_y_d;
      colour <= colour_d;
    end
  end

endmodule

// File: tb/tb_paddle_draw.sv
// Directed bench for paddle_draw: reset, skip/erase paths, clipping, ignored
// starts, asynchronous reset mid-sweep and back-to-back redraws.
module tb_paddle_draw;

  localparam int N = 34;

  logic       clk;
  logic       reset;
  logic [7:0] x_in;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic       plot;

  int checks = 0;
  int errors = 0;

  paddle_draw dut (
    .clk    (clk),
    .reset  (reset),
    .x_in   (x_in),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .vga_x  (vga_x),
    .vga_y  (vga_y),
    .colour (colour),
    .plot   (plot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    x_in  = 8'd0;
    #23;
    checks++;
    if ({plot, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000", {plot, busy, done});
    end
    checks++;
    if ({vga_x, vga_y, colour} !== 18'd0) begin
      errors++;
      $display("FAIL reset_data got x=%0d y=%0d c=%0d want 0", vga_x, vga_y, colour);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    checks++;
    if ({plot, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset got %b want 000", {plot, busy, done});
    end
  endtask

  // One full redraw from idle: per-cycle pixel checks, done timing, plot count.
  task automatic test_redraw(input string name, input logic [7:0] x, input logic [7:0] prev,
                             input int exp_draw_plots);
    bit   erase;
    int   total, idx, row, col, centre, s, draw_plots;
    bit   ph_erase, exp_plot;
    logic [7:0] ex;
    erase      = (x != prev);
    total      = erase ? 2 * N : N;
    draw_plots = 0;
    x_in  = x;
    start = 1'b1;
    tick();
    start = 1'b0;
    x_in  = 8'd0;
    for (int c = 0; c < total; c++) begin
      ph_erase = erase && (c < N);
      idx      = c % N;
      row      = idx / 17;
      col      = idx % 17;
      centre   = ph_erase ? int'(prev) : int'(x);
      s        = centre + col;
      exp_plot = (s >= 8) && (s - 8 < 160);
      ex       = 8'(s - 8);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_done cyc %0d got %b%b want 10", name, c + 1, busy, done);
      end
      checks++;
      if (plot !== exp_plot) begin
        errors++;
        $display("FAIL %s plot cyc %0d got %b want %b", name, c + 1, plot, exp_plot);
      end
      if (exp_plot) begin
        checks++;
        if (vga_x !== ex || vga_y !== 7'(110 + row) ||
            colour !== (ph_erase ? 3'b000 : 3'b111)) begin
          errors++;
          $display("FAIL %s pixel cyc %0d got x=%0d y=%0d c=%b want x=%0d y=%0d c=%b", name,
                   c + 1, vga_x, vga_y, colour, ex, 110 + row, ph_erase ? 3'b000 : 3'b111);
        end
        if (!ph_erase) draw_plots++;
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || plot !== 1'b0) begin
      errors++;
      $display("FAIL %s done_cycle %0d got done=%b busy=%b plot=%b want 1 0 0", name,
               total + 1, done, busy, plot);
    end
    checks++;
    if (draw_plots !== exp_draw_plots) begin
      errors++;
      $display("FAIL %s draw_plot_count got %0d want %0d", name, draw_plots, exp_draw_plots);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after_done got done=%b busy=%b want 0 0", name, done, busy);
    end
  endtask

  // Starts at cycles 5, 40 and in the done cycle must be ignored; x_in changes too.
  task automatic test_ignore_start();
    int ndone, dcyc;
    ndone = 0;
    dcyc  = -1;
    x_in  = 8'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 2 * N + 1; c++) begin
      if (done === 1'b1) begin
        ndone++;
        dcyc = c;
      end
      start = (c == 5 || c == 40 || c == 2 * N + 1);
      x_in  = start ? 8'd50 : 8'd99;
      tick();
    end
    start = 1'b0;
    checks++;
    if (ndone !== 1 || dcyc !== 2 * N + 1) begin
      errors++;
      $display("FAIL ignore_done got count=%0d cyc=%0d want 1 at %0d", ndone, dcyc, 2 * N + 1);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle got busy=%b done=%b want 0 0", busy, done);
    end
    // Skip path here proves old_x took the first accepted value.
    test_redraw("ignore_keep", 8'd100, 8'd100, 34);
  endtask

  task automatic test_reset_mid_draw();
    x_in  = 8'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    checks++;
    if (busy !== 1'b1 || plot !== 1'b1) begin
      errors++;
      $display("FAIL mid_draw_active got busy=%b plot=%b want 1 1", busy, plot);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({plot, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_async got %b want 000", {plot, busy, done});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    // old_x returns to 70, so 70 must take the skip path.
    test_redraw("after_reset_skip", 8'd70, 8'd70, 34);
  endtask

  task automatic test_back_to_back();
    test_redraw("b2b_first", 8'd90, 8'd70, 34);
    test_redraw("b2b_second", 8'd160, 8'd90, 16);
  endtask

  initial begin
    test_reset();
    test_redraw("skip", 8'd70, 8'd70, 34);
    test_redraw("move", 8'd71, 8'd70, 34);
    test_redraw("left_clip", 8'd3, 8'd71, 24);
    test_redraw("right_clip", 8'd155, 8'd3, 26);
    test_ignore_start();
    test_reset_mid_draw();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
